priority_rr_arbiter: RTL and testbench
======================================

// Module: priority_rr_arbiter
// PURPOSE
//  Sequential, parametrised arbiter: WIDTH requesters share one valid/ready grant channel.
//  Built on the tree priority encoder; adds a rotating (round-robin) priority pointer.
//  Adds grant locking while a handshake stalls, and a per-requester ready return.
//  Sits in front of a shared resource (bus port, memory bank, FIFO write side).
// PARAMETERS
//  WIDTH           16  number of requesters; WIDTH >= 2, need not be a power of two
//  SPLIT           4   tree encoder branching factor, passed to the encoder sub-module
//  MODE            1   0: fixed priority (index 0 highest); 1: round-robin
//  IMPLEMENTATION  0   encoder implementation select, passed through unchanged
// PORTS
//  clk      input   1          clock, all state on rising edge
//  rst      input   1          reset, synchronous, active-high
//  req_vld  input   WIDTH      per-requester request valid
//  req_rdy  output  WIDTH      one-hot: req_rdy[i] = gnt_vld & gnt_rdy & (gnt_idx==i)
//  gnt_vld  output  1          a grant is presented
//  gnt_rdy  input   1          downstream accepts the grant
//  gnt_idx  output  WIDTH_LOG  granted index, WIDTH_LOG = $clog2(WIDTH)
//  gnt_oht  output  WIDTH      granted index, one-hot; all zero when gnt_vld=0
// BEHAVIOUR
//  - State: ptr [WIDTH_LOG] (highest-priority index), lck (1 bit), lck_idx [WIDTH_LOG].
//  - Reset: ptr=0, lck=0, lck_idx=0. Outputs are combinational from state and inputs;
//    with req_vld=0 they are gnt_vld=0, gnt_oht=0, req_rdy=0, gnt_idx=0.
//  - Unlocked arbitration, 0-cycle latency:
//    - MODE 0: winner = lowest set bit of req_vld.
//    - MODE 1: masked = req_vld & (bits >= ptr); winner = lowest set bit of masked.
//      If masked is 0, winner = lowest set bit of req_vld.
//  - gnt_vld = |req_vld when unlocked; gnt_vld = req_vld[lck_idx] when locked.
//  - Locked: gnt_idx/gnt_oht = lck_idx; new requests are ignored.
//  - Lock set: gnt_vld & !gnt_rdy & !lck -> next cycle lck=1, lck_idx=current winner.
//  - Lock clear: handshake (gnt_vld & gnt_rdy), or locked requester drops req_vld.
//    - On a drop: gnt_vld=0 that cycle, lck clears next cycle, ptr unchanged.
//  - Handshake: exactly one req_rdy bit high for one cycle.
//    - MODE 1: ptr <= (gnt_idx==WIDTH-1) ? 0 : gnt_idx+1 (explicit wrap, non-pow2 safe).
//    - MODE 0: ptr stays 0.
//  - Simultaneous: a new request arriving on the handshake cycle is not granted that cycle.
//    It competes next cycle against the updated ptr.
//  - Never grant an index whose req_vld=0. gnt_idx is never >= WIDTH.
//  - rst mid-lock: lock is dropped and ptr returns to 0 on the same edge.
//    No req_rdy pulse is produced while rst=1.
//  - X on req_vld bits below the winner propagates; X above the winner must not disturb it.
// STRUCTURE
//  - Shared package: function prio_width_log(WIDTH), and arbiter mode enum
//    arb_mode_t {ARB_FIXED=0, ARB_RR=1}.
//  - Sub-module: priority_to_onehot_tree (dec_vld/enc_idx/enc_vld), two instances.
//    - One on the masked vector, one on the raw vector; the select picks between them.
//  - One always_ff holds ptr/lck/lck_idx; one always_comb does mask, select, outputs.
//  - Thermometer mask generated from ptr by comparison loop, no shifter.
// TESTING (WIDTH=16, SPLIT=4; both MODE values, both IMPLEMENTATION values)
//  1. rst=1 three cycles, req_vld=16'hFFFF -> gnt_vld=0, req_rdy=0, ptr=0.
//     After release: gnt_idx=0.
//  2. MODE 1, req_vld=16'hFFFF, gnt_rdy=1 for 20 cycles -> gnt_idx runs 0,1..15,0,1,2,3.
//     req_rdy is one-hot each cycle.
//  3. MODE 1, req_vld=16'h8001, gnt_rdy=1 -> grants alternate 0,15,0,15.
//     MODE 0 -> always 0.
//  4. Stall: req_vld=16'h0030, gnt_rdy=0 for 4 cycles, idx=4 held.
//     Raise req_vld[0] mid-stall -> idx stays 4. Then gnt_rdy=1 -> req_rdy=16'h0010.
//     Next grant: 5.
//  5. Drop: lock on idx 7, deassert req_vld[7] -> gnt_vld=0 that cycle.
//     Next cycle: grant per unchanged ptr, no req_rdy pulse for 7.
//  6. WIDTH=5 build: ptr at 4, grant 4 -> ptr wraps to 0.
//     Random 10k cycles vs a behavioural model: no starvation beyond WIDTH grants.

Source files
------------

// File: rtl/priority_rr_arbiter_pkg.sv
// Shared definitions for the priority / round-robin arbiter and its encoder.
package priority_rr_arbiter_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_t;

    // Index width for a vector of the given width; never narrower than one bit.
    function automatic int prio_width_log(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/priority_to_onehot_tree.sv
// Lowest-set-bit priority encoder: flat scan (IMPLEMENTATION 0) or a
// SPLIT-way grouped tree (IMPLEMENTATION 1). Index 0 has the highest priority.
module priority_to_onehot_tree
    import priority_rr_arbiter_pkg::*;
#(
    parameter  int WIDTH          = 16,
    parameter  int SPLIT          = 4,
    parameter  int IMPLEMENTATION = 0,
    localparam int WL             = prio_width_log(WIDTH)
) (
    input  logic [WIDTH-1:0] dec_vld,
    output logic [WL-1:0]    enc_idx,
    output logic             enc_vld
);

    generate
        if (IMPLEMENTATION == 0) begin : g_flat
            // Scan from the top down so the lowest set bit is the last writer.
            always_comb begin
                enc_idx = '0;
                enc_vld = 1'b0;
                for (int i = WIDTH - 1; i >= 0; i--) begin
                    if (dec_vld[i]) begin
                        enc_idx = WL'(i);
                        enc_vld = 1'b1;
                    end
                end
            end
        end else begin : g_tree
            localparam int NGRP = (WIDTH + SPLIT - 1) / SPLIT;

            logic [NGRP*SPLIT-1:0] pad;
            logic [NGRP-1:0]       grp_any;
            int                    gsel;
            int                    bsel;

            always_comb begin
                pad            = '0;
                pad[WIDTH-1:0] = dec_vld;
            end

            for (genvar g = 0; g < NGRP; g++) begin : g_grp
                assign grp_any[g] = |pad[g*SPLIT +: SPLIT];
            end

            // Pick the lowest non-empty group, then the lowest bit inside it.
            always_comb begin
                gsel = 0;
                for (int g = NGRP - 1; g >= 0; g--) begin
                    if (grp_any[g]) gsel = g;
                end
                bsel = 0;
                for (int b = SPLIT - 1; b >= 0; b--) begin
                    if (pad[gsel*SPLIT + b]) bsel = b;
                end
                enc_vld = |grp_any;
                enc_idx = WL'(gsel * SPLIT + bsel);
            end
        end
    endgenerate

endmodule

// File: rtl/priority_rr_arbiter.sv
// WIDTH-way arbiter onto one valid/ready grant channel, fixed or round-robin
// priority, with the grant locked while the downstream stalls.
module priority_rr_arbiter
    import priority_rr_arbiter_pkg::*;
#(
    parameter  int WIDTH          = 16,
    parameter  int SPLIT          = 4,
    parameter  int MODE           = 1,
    parameter  int IMPLEMENTATION = 0,
    localparam int WIDTH_LOG      = prio_width_log(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     req_vld,
    output logic [WIDTH-1:0]     req_rdy,
    output logic                 gnt_vld,
    input  logic                 gnt_rdy,
    output logic [WIDTH_LOG-1:0] gnt_idx,
    output logic [WIDTH-1:0]     gnt_oht
);

    logic [WIDTH_LOG-1:0] ptr_q, ptr_d;
    logic                 lck_q, lck_d;
    logic [WIDTH_LOG-1:0] lck_idx_q, lck_idx_d;

    logic [WIDTH-1:0]     mask;
    logic [WIDTH-1:0]     masked;
    logic [WIDTH_LOG-1:0] msk_idx, raw_idx, win_idx;
    logic                 msk_vld, raw_vld, hs;

    // Thermometer: every index at or above the pointer stays eligible.
    for (genvar i = 0; i < WIDTH; i++) begin : g_mask
        assign mask[i] = (WIDTH_LOG'(i) >= ptr_q);
    end
    assign masked = req_vld & mask;

    priority_to_onehot_tree #(
        .WIDTH(WIDTH), .SPLIT(SPLIT), .IMPLEMENTATION(IMPLEMENTATION)
    ) u_enc_msk (
        .dec_vld(masked), .enc_idx(msk_idx), .enc_vld(msk_vld)
    );

    priority_to_onehot_tree #(
        .WIDTH(WIDTH), .SPLIT(SPLIT), .IMPLEMENTATION(IMPLEMENTATION)
    ) u_enc_raw (
        .dec_vld(req_vld), .enc_idx(raw_idx), .enc_vld(raw_vld)
    );

    always_comb begin
        win_idx = (MODE == int'(ARB_RR) && msk_vld) ? msk_idx : raw_idx;

        if (lck_q) begin
            gnt_idx = lck_idx_q;
            gnt_vld = req_vld[lck_idx_q] & ~rst;
        end else begin
            gnt_idx = win_idx;
            gnt_vld = raw_vld & ~rst;
        end

        gnt_oht = '0;
        if (gnt_vld) gnt_oht[gnt_idx] = 1'b1;

        hs      = gnt_vld & gnt_rdy;
        req_rdy = hs ? gnt_oht : '0;

        ptr_d     = ptr_q;
        lck_d     = lck_q;
        lck_idx_d = lck_idx_q;
        if (hs) begin
            lck_d = 1'b0;
            if (MODE == int'(ARB_RR))
                ptr_d = (gnt_idx == WIDTH_LOG'(WIDTH - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (lck_q && !req_vld[lck_idx_q]) begin
            // Locked requester withdrew: release without moving the pointer.
            lck_d = 1'b0;
        end else if (gnt_vld && !lck_q) begin
            lck_d     = 1'b1;
            lck_idx_d = gnt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            lck_q     <= 1'b0;
            lck_idx_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            lck_q     <= lck_d;
            lck_idx_q <= lck_idx_d;
        end
    end

endmodule

// File: tb/tb_priority_rr_arbiter.sv
// Directed checks of the arbiter in both modes and encoder variants, plus a
// randomised WIDTH=5 run against a rotating-search reference.
module tb_priority_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic        rdy;
    logic [4:0]  req5;
    logic        rdy5;

    logic [15:0] rr0_rdy, rr0_oht, rr1_rdy, rr1_oht, fx_rdy, fx_oht;
    logic [3:0]  rr0_idx, rr1_idx, fx_idx;
    logic        rr0_vld, rr1_vld, fx_vld;
    logic [4:0]  w5_rdy, w5_oht;
    logic [2:0]  w5_idx;
    logic        w5_vld;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    priority_rr_arbiter #(.WIDTH(16), .SPLIT(4), .MODE(1), .IMPLEMENTATION(0)) u_rr0 (
        .clk(clk), .rst(rst), .req_vld(req), .req_rdy(rr0_rdy), .gnt_vld(rr0_vld),
        .gnt_rdy(rdy), .gnt_idx(rr0_idx), .gnt_oht(rr0_oht));

    priority_rr_arbiter #(.WIDTH(16), .SPLIT(4), .MODE(1), .IMPLEMENTATION(1)) u_rr1 (
        .clk(clk), .rst(rst), .req_vld(req), .req_rdy(rr1_rdy), .gnt_vld(rr1_vld),
        .gnt_rdy(rdy), .gnt_idx(rr1_idx), .gnt_oht(rr1_oht));

    priority_rr_arbiter #(.WIDTH(16), .SPLIT(4), .MODE(0), .IMPLEMENTATION(0)) u_fx (
        .clk(clk), .rst(rst), .req_vld(req), .req_rdy(fx_rdy), .gnt_vld(fx_vld),
        .gnt_rdy(rdy), .gnt_idx(fx_idx), .gnt_oht(fx_oht));

    priority_rr_arbiter #(.WIDTH(5), .SPLIT(4), .MODE(1), .IMPLEMENTATION(1)) u_w5 (
        .clk(clk), .rst(rst), .req_vld(req5), .req_rdy(w5_rdy), .gnt_vld(w5_vld),
        .gnt_rdy(rdy5), .gnt_idx(w5_idx), .gnt_oht(w5_oht));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic chk_one(input string tag, input logic av, input logic [3:0] ai,
                           input logic [15:0] ar, input logic [15:0] ao,
                           input logic v, input logic [3:0] i, input logic [15:0] r);
        chk({tag, ".vld"}, av, v);
        if (v) chk({tag, ".idx"}, ai, i);
        chk({tag, ".rdy"}, ar, r);
        chk({tag, ".oht"}, ao, v ? (16'd1 << i) : 16'd0);
    endtask

    task automatic chk_rr(input string tag, input logic v, input logic [3:0] i, input logic [15:0] r);
        chk_one({tag, ".rr0"}, rr0_vld, rr0_idx, rr0_rdy, rr0_oht, v, i, r);
        chk_one({tag, ".rr1"}, rr1_vld, rr1_idx, rr1_rdy, rr1_oht, v, i, r);
    endtask

    task automatic chk_fx(input string tag, input logic v, input logic [3:0] i, input logic [15:0] r);
        chk_one({tag, ".fx"}, fx_vld, fx_idx, fx_rdy, fx_oht, v, i, r);
    endtask

    task automatic chk_w5(input string tag, input logic v, input logic [2:0] i, input logic [4:0] r);
        chk_one({tag, ".w5"}, w5_vld, {1'b0, w5_idx}, {11'd0, w5_rdy}, {11'd0, w5_oht},
                v, {1'b0, i}, {11'd0, r});
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    logic [2:0] m_ptr, m_lidx, ei;
    logic       m_lck, ev, hs, found;
    int         waitc [5];

    initial begin
        rst  = 1'b1;
        req  = 16'hFFFF;
        rdy  = 1'b1;
        req5 = 5'h1F;
        rdy5 = 1'b1;

        // Reset held three cycles with everything requesting
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_rr("rst", 1'b0, 4'd0, 16'h0000);
            chk_fx("rst", 1'b0, 4'd0, 16'h0000);
            chk_w5("rst", 1'b0, 3'd0, 5'h00);
            step();
        end
        rst  = 1'b0;
        req5 = 5'h00;

        // Full request, always ready: rotation through every index
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk_rr("seq", 1'b1, 4'(k % 16), 16'd1 << (k % 16));
            chk_fx("seq", 1'b1, 4'd0, 16'h0001);
            step();
        end

        // Two requesters at opposite ends
        do_reset();
        req = 16'h8001;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk_rr("alt", 1'b1, (k % 2) ? 4'd15 : 4'd0, (k % 2) ? 16'h8000 : 16'h0001);
            chk_fx("alt", 1'b1, 4'd0, 16'h0001);
            step();
        end

        // Stall locks idx 4; a new higher-priority request must not steal it
        do_reset();
        req = 16'h0030;
        rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) req = 16'h0031;
            @(negedge clk);
            chk_rr("stall", 1'b1, 4'd4, 16'h0000);
            chk_fx("stall", 1'b1, 4'd4, 16'h0000);
            step();
        end
        rdy = 1'b1;
        @(negedge clk);
        chk_rr("stall_hs", 1'b1, 4'd4, 16'h0010);
        chk_fx("stall_hs", 1'b1, 4'd4, 16'h0010);
        step();
        req = 16'h0021;
        @(negedge clk);
        chk_rr("after_stall", 1'b1, 4'd5, 16'h0020);
        chk_fx("after_stall", 1'b1, 4'd0, 16'h0001);
        step();

        // Locked requester 7 withdraws
        do_reset();
        req = 16'h0080;
        rdy = 1'b0;
        @(negedge clk);
        chk_rr("drop_lock", 1'b1, 4'd7, 16'h0000);
        chk_fx("drop_lock", 1'b1, 4'd7, 16'h0000);
        step();
        req = 16'h0104;
        @(negedge clk);
        chk_rr("drop", 1'b0, 4'd7, 16'h0000);
        chk_fx("drop", 1'b0, 4'd7, 16'h0000);
        step();
        rdy = 1'b1;
        @(negedge clk);
        chk_rr("post_drop", 1'b1, 4'd2, 16'h0004);
        chk_fx("post_drop", 1'b1, 4'd2, 16'h0004);
        step();

        // Reset asserted while locked: lock released, no ready pulse
        rdy = 1'b0;
        req = 16'h0008;
        step();
        rst = 1'b1;
        rdy = 1'b1;
        @(negedge clk);
        chk_rr("rst_lock", 1'b0, 4'd3, 16'h0000);
        step();
        rst = 1'b0;
        req = 16'h0001;
        @(negedge clk);
        chk_rr("rst_unlock", 1'b1, 4'd0, 16'h0001);
        step();

        // WIDTH=5 pointer wrap from 4 back to 0
        req = 16'h0000;
        do_reset();
        rdy5 = 1'b1;
        req5 = 5'h08;
        @(negedge clk);
        chk_w5("w5_a", 1'b1, 3'd3, 5'h08);
        step();
        req5 = 5'h1F;
        @(negedge clk);
        chk_w5("w5_b", 1'b1, 3'd4, 5'h10);
        step();
        @(negedge clk);
        chk_w5("w5_wrap", 1'b1, 3'd0, 5'h01);
        step();
        @(negedge clk);
        chk_w5("w5_next", 1'b1, 3'd1, 5'h02);
        step();

        // Randomised WIDTH=5 run; requests are held until granted
        req5 = 5'h00;
        rdy5 = 1'b0;
        do_reset();
        m_ptr  = '0;
        m_lck  = 1'b0;
        m_lidx = '0;
        for (int j = 0; j < 5; j++) waitc[j] = 0;
        for (int n = 0; n < 10000; n++) begin
            rdy5 = 1'($urandom_range(0, 1));
            for (int j = 0; j < 5; j++)
                if (!req5[j] && $urandom_range(0, 2) == 0) req5[j] = 1'b1;

            ei    = '0;
            found = 1'b0;
            if (m_lck) begin
                ev = req5[m_lidx];
                ei = m_lidx;
            end else begin
                ev = |req5;
                for (int j = 0; j < 5; j++) begin
                    int c;
                    c = (int'(m_ptr) + j) % 5;
                    if (!found && req5[c]) begin
                        ei    = 3'(c);
                        found = 1'b1;
                    end
                end
            end
            hs = ev & rdy5;

            @(negedge clk);
            chk("rnd.vld", w5_vld, ev);
            if (ev) chk("rnd.idx", w5_idx, ei);
            chk("rnd.rdy", w5_rdy, hs ? (5'd1 << ei) : 5'd0);
            step();

            if (hs) begin
                m_ptr = (ei == 3'd4) ? 3'd0 : ei + 3'd1;
                m_lck = 1'b0;
                chk("rnd.starve", waitc[ei] <= 4, 1);
                waitc[ei] = 0;
                req5[ei]  = 1'b0;
                for (int j = 0; j < 5; j++)
                    if (req5[j]) waitc[j]++;
            end else if (m_lck && !req5[m_lidx]) begin
                m_lck = 1'b0;
            end else if (ev && !m_lck) begin
                m_lck  = 1'b1;
                m_lidx = ei;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
